lsu_store_buffer_unit: RTL

//  Load/store unit between the CPU execute stage and the 4-byte-lane data memory (DM).

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/lsu_store_buffer_unit_if.sv | 23 ++
 rtl/lsu_sb_fifo.sv | 95 +++++++++
 rtl/lsu_store_buffer_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU store-buffer slice: funct3 codes, FSM encoding,
// buffered-store payload and the lane/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_HIT_DRAIN = 2'd2;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_payload_t;

  localparam int unsigned SB_PAYLOAD_W = $bits(sb_payload_t);

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << {off[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   store_align = {4{wdata[7:0]}};
      2'b01:   store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  load_extend = {24'h0, sh[7:0]};
      F3_LHU:  load_extend = {16'h0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_buffer_unit_if.sv
// CPU-side request/response bundle of the LSU; the LSU is the slave, the CPU the master.
interface lsu_store_buffer_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        sb_empty;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, misalign, sb_empty
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, misalign, sb_empty
  );
endinterface

// File: rtl/lsu_sb_fifo.sv
// Store-buffer FIFO with a parallel word-address/lane-overlap compare against all entries.
// LSU_STORE_FWD_EN adds the youngest-overlapping-entry forwarding outputs.
module lsu_sb_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  sb_payload_t                push_ent,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output sb_payload_t                head_ent,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          cmp_addr,
  input  logic [3:0]                 cmp_mask,
`ifdef LSU_STORE_FWD_EN
  output logic                       fwd_ok,
  output logic [31:0]                fwd_data,
`else
`endif
  output logic [DEPTH-1:0]           hit_vec
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  sb_payload_t       ent_q  [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      ent_q[wr_ptr]  <= push_ent;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_ent  = ent_q[rd_ptr];
  assign full      = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty     = (count == '0);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_vec[i] = vld_q[i] && (addr_q[i] == cmp_addr) && ((ent_q[i].mask & cmp_mask) != 4'b0000);
    end
  end

`ifdef LSU_STORE_FWD_EN
  // Walk oldest to youngest so the last overlapping entry seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_ok   = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (hit_vec[idx]) begin
        fwd_ok   = ((ent_q[idx].mask & cmp_mask) == cmp_mask);
        fwd_data = ent_q[idx].data;
      end
    end
  end
`else
`endif

endmodule

// File: rtl/lsu_store_buffer_unit.sv
// Load/store unit with posted-store FIFO in front of a 4-lane data memory.
// Build option LSU_STORE_FWD_EN: fully covered loads are answered from the store buffer.
module lsu_store_buffer_unit
  import lsu_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_store_buffer_unit_if.slave bus,
  output logic                  dm_en,
  output logic [3:0]            dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [31:0]           dm_di,
  input  logic [31:0]           dm_do
);
  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   word_addr, head_addr;
  logic [3:0]          lmask;
  sb_payload_t         push_ent, head_ent;
  logic [SB_DEPTH-1:0] hit_vec;
  logic                full, empty;
  logic [CNT_W-1:0]    count;
  logic                misal, hit, fwd_ok, is_load, blocked_hit;
  logic                accept, st_push, ld_acc, ld_dm, drain;
  logic [31:0]         fwd_data;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                fwd_q, misalign_q;
  logic [31:0]         fwd_data_q;
  logic                unused_addr;

  assign word_addr   = bus.req_addr[ADDR_W+1:2];
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
  assign lmask       = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
  assign misal       = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign hit         = |hit_vec;

  // rst gates the request path so nothing reaches DM while reset is held.
  assign is_load     = rst && bus.req_valid && !bus.req_we && !misal;
  assign blocked_hit = is_load && hit && !fwd_ok;

  assign bus.req_ready = (state_q == ST_IDLE) &&
                         (misal || (bus.req_we ? !full : !(hit && !fwd_ok)));

  assign accept   = rst && bus.req_valid && bus.req_ready;
  assign st_push  = accept && bus.req_we && !misal;
  assign ld_acc   = accept && !bus.req_we && !misal;
  assign ld_dm    = ld_acc && !fwd_ok;
  assign drain    = !empty && !ld_dm;

  assign push_ent.mask = lmask;
  assign push_ent.data = store_align(bus.req_funct3, bus.req_wdata);

  lsu_sb_fifo #(
    .DEPTH  (SB_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (st_push),
    .push_addr (word_addr),
    .push_ent  (push_ent),
    .pop       (drain),
    .head_addr (head_addr),
    .head_ent  (head_ent),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .cmp_addr  (word_addr),
    .cmp_mask  (lmask),
`ifdef LSU_STORE_FWD_EN
    .fwd_ok    (fwd_ok),
    .fwd_data  (fwd_data),
`else
`endif
    .hit_vec   (hit_vec)
  );

`ifdef LSU_STORE_FWD_EN
`else
  assign fwd_ok   = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_acc)           state_d = ST_LOAD_WAIT;
        else if (blocked_hit) state_d = ST_HIT_DRAIN;
      end
      ST_LOAD_WAIT:           state_d = ST_IDLE;
      ST_HIT_DRAIN: begin
        if (!blocked_hit)     state_d = ST_IDLE;
      end
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= accept && misal;
      if (ld_acc) begin
        f3_q       <= bus.req_funct3;
        off_q      <= bus.req_addr[1:0];
        fwd_q      <= fwd_ok;
        fwd_data_q <= fwd_data;
      end
    end
  end

  assign bus.resp_valid = (state_q == ST_LOAD_WAIT);
  assign bus.resp_rdata = bus.resp_valid ? load_extend(f3_q, off_q, fwd_q ? fwd_data_q : dm_do) : '0;
  assign bus.misalign   = misalign_q;
  assign bus.sb_empty   = (count == '0) && !drain;

  assign dm_en   = ld_dm || drain;
  assign dm_we   = drain ? head_ent.mask : '0;
  assign dm_addr = ld_dm ? word_addr : (drain ? head_addr : '0);
  assign dm_di   = drain ? head_ent.data : '0;

endmodule
